// File: rtl/iouart.sv
// Memory-mapped 8N1 UART: TX shifter, RX sampler with a 4-deep FIFO,
// a sticky status register and a 16-bit baud divisor on two byte lanes.
module iouart #(
    parameter logic [14:0] ADDRBASE = 15'h0010,
    parameter logic [15:0] DIVRESET = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] read_addr_even,
    input  logic [14:0] read_addr_odd,
    input  logic [14:0] write_addr_even,
    input  logic [14:0] write_addr_odd,
    input  logic [7:0]  write_data_even,
    input  logic [7:0]  write_data_odd,
    input  logic        write_en_even,
    input  logic        write_en_odd,
    output logic [7:0]  read_data_even,
    output logic [7:0]  read_data_odd,
    output logic        txd,
    input  logic        rxd
);
    localparam logic [14:0] ADDR1 = ADDRBASE + 15'd1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [15:0] div_q, div_d;
    state_t      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [7:0]  mem_q [4];
    logic [1:0]  head_q, head_d, wptr;
    logic [2:0]  count_q, count_d, count_after_pop;
    logic        ovr_q, ovr_d, fe_q, fe_d;
    logic [7:0]  rd_even_q, rd_even_d, rd_odd_q, rd_odd_d;
    logic        wr_tx, wr_divlo, wr_stat, wr_divhi;
    logic        tx_tick, rx_tick, rx_push, rx_fe_set, pop, push_ok, ovr_set;
    logic [15:0] rx_half_m1;
    logic [7:0]  rxdata, status;

    assign wr_tx    = write_en_even && (write_addr_even == ADDRBASE);
    assign wr_divlo = write_en_even && (write_addr_even == ADDR1);
    assign wr_stat  = write_en_odd  && (write_addr_odd  == ADDRBASE);
    assign wr_divhi = write_en_odd  && (write_addr_odd  == ADDR1);

    always_comb begin
        div_d = div_q;
        if (wr_divlo) div_d[7:0]  = write_data_even;
        if (wr_divhi) div_d[15:8] = write_data_odd;
    end

    // Bit counters count down and reload from DIV at each boundary, so a
    // DIV change lands on the next bit.
    assign tx_tick = (tx_cnt_q == 16'd0);
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick ? div_q : tx_cnt_q - 16'd1;
        case (tx_state_q)
            S_IDLE: if (wr_tx) begin
                tx_sh_d    = write_data_even;
                tx_cnt_d   = div_q;
                tx_state_d = S_START;
            end
            S_START: if (tx_tick) begin
                tx_state_d = S_DATA;
                tx_bit_d   = 3'd0;
            end
            S_DATA: if (tx_tick) begin
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
            end
            default: if (tx_tick) tx_state_d = S_IDLE;
        endcase
    end

    assign txd = (tx_state_q == S_START) ? 1'b0 :
                 (tx_state_q == S_DATA)  ? tx_sh_q[0] : 1'b1;

    // (DIV+1)>>1 clocks to the start-bit sample, expressed as a reload value.
    assign rx_half_m1 = (div_q[0] || div_q == 16'd0) ? (div_q >> 1) : (div_q >> 1) - 16'd1;
    assign rx_tick    = (rx_cnt_q == 16'd0);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        rx_fe_set  = 1'b0;
        if (rx_state_q != S_IDLE) rx_cnt_d = rx_tick ? div_q : rx_cnt_q - 16'd1;
        case (rx_state_q)
            S_IDLE: if (rx_s3_q && !rx_s2_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = rx_half_m1;
            end
            S_START: if (rx_tick) begin
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                rx_bit_d   = 3'd0;
            end
            S_DATA: if (rx_tick) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
            default: if (rx_tick) begin
                rx_push    = 1'b1;
                rx_fe_set  = !rx_s2_q;
                rx_state_d = S_IDLE;
            end
        endcase
    end

    // A same-cycle pop frees the slot before the push is judged.
    assign pop             = wr_stat && write_data_odd[7] && (count_q != 3'd0);
    assign count_after_pop = count_q - {2'b0, pop};
    assign push_ok         = rx_push && (count_after_pop != 3'd4);
    assign ovr_set         = rx_push && (count_after_pop == 3'd4);
    assign wptr            = head_q + count_q[1:0];
    assign count_d         = count_after_pop + {2'b0, push_ok};
    assign head_d          = head_q + {1'b0, pop};
    assign ovr_d           = (ovr_q & ~(wr_stat & write_data_odd[2])) | ovr_set;
    assign fe_d            = (fe_q  & ~(wr_stat & write_data_odd[3])) | rx_fe_set;

    assign rxdata = (count_q != 3'd0) ? mem_q[head_q] : 8'h00;
    assign status = {1'b0, count_q, fe_q, ovr_q, count_q != 3'd0, tx_state_q != S_IDLE};

    always_comb begin
        rd_even_d = 8'h00;
        rd_odd_d  = 8'h00;
        if (read_addr_even == ADDRBASE)   rd_even_d = rxdata;
        else if (read_addr_even == ADDR1) rd_even_d = div_q[7:0];
        if (read_addr_odd == ADDRBASE)    rd_odd_d  = status;
        else if (read_addr_odd == ADDR1)  rd_odd_d  = div_q[15:8];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= DIVRESET;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            head_q     <= 2'd0;
            count_q    <= 3'd0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            rd_even_q  <= 8'h00;
            rd_odd_q   <= 8'h00;
        end else begin
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            head_q     <= head_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            rd_even_q  <= rd_even_d;
            rd_odd_q   <= rd_odd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr] <= rx_sh_q;
    end

    assign read_data_even = rd_even_q;
    assign read_data_odd  = rd_odd_q;
endmodule

// File: tb/tb_iouart.sv
// Directed bench for iouart: register-access vector table followed by
// serial TX/RX sequences at DIV=3 (4 clocks per bit).
module tb_iouart;
    localparam logic [14:0] AB = 15'h0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] ra_e = '0, ra_o = '0, wa_e = '0, wa_o = '0;
    logic [7:0]  wd_e = '0, wd_o = '0;
    logic        we_e = 1'b0, we_o = 1'b0;
    logic [7:0]  rd_e, rd_o;
    logic        txd;
    logic        rxd = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    iouart #(.ADDRBASE(AB), .DIVRESET(16'd103)) dut (
        .clk(clk), .reset(reset),
        .read_addr_even(ra_e), .read_addr_odd(ra_o),
        .write_addr_even(wa_e), .write_addr_odd(wa_o),
        .write_data_even(wd_e), .write_data_odd(wd_o),
        .write_en_even(we_e), .write_en_odd(we_o),
        .read_data_even(rd_e), .read_data_odd(rd_o),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we_e;
        logic [14:0] wa_e;
        logic [7:0]  wd_e;
        logic        we_o;
        logic [14:0] wa_o;
        logic [7:0]  wd_o;
        logic [14:0] ra_e;
        logic [14:0] ra_o;
        logic [7:0]  exp_e;
        logic [7:0]  exp_o;
    } vec_t;

    vec_t vt [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [7:0] exp_e, input logic [7:0] exp_o);
        tick();
        chk({name, ".even"}, rd_e, exp_e);
        chk({name, ".odd"},  rd_o, exp_o);
    endtask

    task automatic wr_stat(input logic [7:0] d);
        we_o = 1'b1; wa_o = AB; wd_o = d;
        tick();
        we_o = 1'b0;
    endtask

    // Frame at 4 clocks per bit, followed by two idle bit times.
    task automatic send_byte(input logic [7:0] d, input logic stopb);
        logic [9:0] bits;
        bits = {stopb, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (4) tick();
        end
        rxd = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        logic [9:0] pat;
        logic [7:0] d5;
        int busy;

        vt[0] = '{0, AB,       8'h00, 0, AB,       8'h00, AB,       AB,       8'h00, 8'h00};
        vt[1] = '{0, AB,       8'h00, 0, AB,       8'h00, AB+15'd1, AB+15'd1, 8'h67, 8'h00};
        vt[2] = '{1, AB+15'd1, 8'h34, 1, AB+15'd1, 8'h12, AB+15'd1, AB+15'd1, 8'h67, 8'h00};
        vt[3] = '{0, AB,       8'h00, 0, AB,       8'h00, AB+15'd1, AB+15'd1, 8'h34, 8'h12};
        vt[4] = '{0, AB,       8'h00, 0, AB,       8'h00, 15'h0000, 15'h7FFF, 8'h00, 8'h00};
        vt[5] = '{1, AB+15'd1, 8'h03, 1, AB+15'd1, 8'h00, AB+15'd2, AB+15'd2, 8'h00, 8'h00};
        vt[6] = '{0, AB,       8'h00, 0, AB,       8'h00, AB+15'd1, AB+15'd1, 8'h03, 8'h00};
        vt[7] = '{0, AB,       8'h00, 1, AB,       8'h0C, AB,       AB,       8'h00, 8'h00};

        reset = 1'b0;
        repeat (2) tick();
        chk("rst.txd", {7'b0, txd}, 8'h01);
        chk("rst.rd_even", rd_e, 8'h00);
        chk("rst.rd_odd", rd_o, 8'h00);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            we_e = vt[i].we_e; wa_e = vt[i].wa_e; wd_e = vt[i].wd_e;
            we_o = vt[i].we_o; wa_o = vt[i].wa_o; wd_o = vt[i].wd_o;
            ra_e = vt[i].ra_e; ra_o = vt[i].ra_o;
            tick();
            chk($sformatf("vec%0d.even", i), rd_e, vt[i].exp_e);
            chk($sformatf("vec%0d.odd", i),  rd_o, vt[i].exp_o);
        end
        we_e = 1'b0; we_o = 1'b0;
        ra_e = AB; ra_o = AB;

        // TX A5; a second write at k=10 must be ignored.
        pat = {1'b1, 8'hA5, 1'b0};
        we_e = 1'b1; wa_e = AB; wd_e = 8'hA5;
        tick();
        busy = 0;
        for (int k = 0; k < 45; k++) begin
            if (k < 40) chk($sformatf("tx.k%0d", k), {7'b0, txd}, {7'b0, pat[k/4]});
            else if (k == 40) chk("tx.idle", {7'b0, txd}, 8'h01);
            busy += int'(rd_o[0]);
            we_e = (k == 10); wd_e = 8'hFF;
            tick();
        end
        we_e = 1'b0;
        chk("tx.busy_cycles", 8'(busy), 8'd40);

        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        rd("rx2", 8'h3C, 8'h22);
        wr_stat(8'h80);
        rd("rx2.pop1", 8'hC3, 8'h12);
        wr_stat(8'h80);
        rd("rx2.pop2", 8'h00, 8'h00);

        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        rd("ovr", 8'h01, 8'h46);
        wr_stat(8'h04);
        rd("ovr.clr", 8'h01, 8'h42);
        wr_stat(8'h80); rd("ovr.p1", 8'h02, 8'h32);
        wr_stat(8'h80); rd("ovr.p2", 8'h03, 8'h22);
        wr_stat(8'h80); rd("ovr.p3", 8'h04, 8'h12);
        wr_stat(8'h80); rd("ovr.p4", 8'h00, 8'h00);

        send_byte(8'h55, 1'b0);
        rd("fe", 8'h55, 8'h1A);
        wr_stat(8'h88);
        rd("fe.clr", 8'h00, 8'h00);
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (20) tick();
        rd("glitch", 8'h00, 8'h00);

        // Full FIFO; pop and TX write land on the cycle the fifth byte pushes.
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1'b1);
        rd("full", 8'h10, 8'h42);
        d5 = 8'h14;
        wa_e = AB; wd_e = 8'h12; wa_o = AB; wd_o = 8'h80;
        for (int c = 0; c < 45; c++) begin
            rxd  = (c < 4) ? 1'b0 : (c < 36) ? d5[(c-4)/4] : 1'b1;
            we_e = (c == 40);
            we_o = (c == 40);
            tick();
        end
        we_e = 1'b0; we_o = 1'b0;
        rd("same", 8'h11, 8'h43);
        repeat (45) tick();
        wr_stat(8'h80); rd("same.p1", 8'h12, 8'h32);
        wr_stat(8'h80); rd("same.p2", 8'h13, 8'h22);
        wr_stat(8'h80); rd("same.p3", 8'h14, 8'h12);
        wr_stat(8'h80); rd("same.p4", 8'h00, 8'h00);

        // Reset in data bit 3 of a TX frame with a byte waiting in the FIFO.
        send_byte(8'h77, 1'b1);
        we_e = 1'b1; wa_e = AB; wd_e = 8'hF0;
        tick();
        we_e = 1'b0;
        repeat (17) tick();
        chk("rst.bit3", {7'b0, txd}, 8'h00);
        reset = 1'b0;
        tick();
        chk("rst.mid.txd", {7'b0, txd}, 8'h01);
        chk("rst.mid.rd_even", rd_e, 8'h00);
        chk("rst.mid.rd_odd", rd_o, 8'h00);
        reset = 1'b1;
        rd("rst.status", 8'h00, 8'h00);
        ra_e = AB + 15'd1; ra_o = AB + 15'd1;
        rd("rst.div", 8'h67, 8'h00);
        tick();
        chk("rst.txd_idle", {7'b0, txd}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
